// File: rtl/bip_control.sv
// Control unit for the accumulator processor: program counter, RUN/HALT FSM,
// combinational instruction decode and a saturating executed-instruction counter.
module bip_control #(
   parameter int PC_BITS  = 11,
   parameter int OPC_BITS = 5,
   parameter int OPR_BITS = 11,
   parameter int CNT_BITS = 16
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic [15:0]         i_instr,
   output logic [PC_BITS-1:0]  o_pc,
   output logic [OPR_BITS-1:0] o_operand,
   output logic [1:0]          o_sel_a,
   output logic                o_sel_b,
   output logic                o_op,
   output logic                o_wr_acc,
   output logic                o_wr_ram,
   output logic                o_rd_ram,
   output logic                o_halt,
   output logic [CNT_BITS-1:0] o_inst_count
);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   localparam logic [OPC_BITS-1:0] OPC_HLT  = OPC_BITS'(0);
   localparam logic [OPC_BITS-1:0] OPC_STO  = OPC_BITS'(1);
   localparam logic [OPC_BITS-1:0] OPC_LD   = OPC_BITS'(2);
   localparam logic [OPC_BITS-1:0] OPC_LDI  = OPC_BITS'(3);
   localparam logic [OPC_BITS-1:0] OPC_ADD  = OPC_BITS'(4);
   localparam logic [OPC_BITS-1:0] OPC_ADDI = OPC_BITS'(5);
   localparam logic [OPC_BITS-1:0] OPC_SUB  = OPC_BITS'(6);
   localparam logic [OPC_BITS-1:0] OPC_SUBI = OPC_BITS'(7);

   state_t              state_q, state_d;
   logic [PC_BITS-1:0]  pc_q, pc_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic [OPC_BITS-1:0] opcode;
   logic                exec;
   logic                is_hlt;
   logic                dec_wr_acc, dec_wr_ram, dec_rd_ram;

   assign opcode    = i_instr[OPC_BITS+OPR_BITS-1 -: OPC_BITS];
   assign o_operand = i_instr[OPR_BITS-1:0];
   // Strobes are suppressed during reset even when the FSM reads RUN.
   assign exec      = !i_reset && i_enable && (state_q == ST_RUN);

   always_comb begin
      o_sel_a    = 2'b00;
      o_sel_b    = 1'b0;
      o_op       = 1'b0;
      dec_wr_acc = 1'b0;
      dec_wr_ram = 1'b0;
      dec_rd_ram = 1'b0;
      is_hlt     = 1'b0;
      case (opcode)
         OPC_HLT:  is_hlt = 1'b1;
         OPC_STO:  dec_wr_ram = 1'b1;
         OPC_LD: begin
            dec_rd_ram = 1'b1;
            dec_wr_acc = 1'b1;
         end
         OPC_LDI: begin
            o_sel_a    = 2'b01;
            dec_wr_acc = 1'b1;
         end
         OPC_ADD, OPC_SUB: begin
            o_sel_a    = 2'b10;
            o_op       = (opcode == OPC_SUB);
            dec_rd_ram = 1'b1;
            dec_wr_acc = 1'b1;
         end
         OPC_ADDI, OPC_SUBI: begin
            o_sel_a    = 2'b10;
            o_sel_b    = 1'b1;
            o_op       = (opcode == OPC_SUBI);
            dec_wr_acc = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_wr_acc = exec && dec_wr_acc;
   assign o_wr_ram = exec && dec_wr_ram;
   assign o_rd_ram = exec && dec_rd_ram;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (exec) begin
         if (cnt_q != {CNT_BITS{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (is_hlt) begin
            state_d = ST_HALT;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_pc         = pc_q;
   assign o_halt       = (state_q == ST_HALT);
   assign o_inst_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: table of per-cycle vectors plus a wrap and
// saturation sequence on a narrow instance.
module tb_bip_control;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] instr;
      logic [1:0]  sel_a;
      logic        sel_b;
      logic        op;
      logic        wr_acc;
      logic        wr_ram;
      logic        rd_ram;
      int          pc;
      logic        halt;
      int          cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [15:0] instr;
   logic [10:0] pc;
   logic [10:0] operand;
   logic [1:0]  sel_a;
   logic        sel_b, op, wr_acc, wr_ram, rd_ram, halt;
   logic [15:0] cnt;

   logic        w_rst, w_en;
   logic [15:0] w_instr;
   logic [2:0]  w_pc;
   logic [10:0] w_operand;
   logic [1:0]  w_sel_a;
   logic        w_sel_b, w_op, w_wr_acc, w_wr_ram, w_rd_ram, w_halt;
   logic [2:0]  w_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bip_control dut (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_instr(instr),
      .o_pc(pc), .o_operand(operand), .o_sel_a(sel_a), .o_sel_b(sel_b),
      .o_op(op), .o_wr_acc(wr_acc), .o_wr_ram(wr_ram), .o_rd_ram(rd_ram),
      .o_halt(halt), .o_inst_count(cnt)
   );

   bip_control #(.PC_BITS(3), .CNT_BITS(3)) u_wrap (
      .i_clock(clk), .i_reset(w_rst), .i_enable(w_en), .i_instr(w_instr),
      .o_pc(w_pc), .o_operand(w_operand), .o_sel_a(w_sel_a), .o_sel_b(w_sel_b),
      .o_op(w_op), .o_wr_acc(w_wr_acc), .o_wr_ram(w_wr_ram), .o_rd_ram(w_rd_ram),
      .o_halt(w_halt), .o_inst_count(w_cnt)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic [15:0] in,
                               input logic [1:0] sa, input logic sb, input logic o,
                               input logic wa, input logic wm, input logic rm,
                               input int p, input logic h, input int c);
      vec_t v;
      v.rst = r; v.en = e; v.instr = in; v.sel_a = sa; v.sel_b = sb; v.op = o;
      v.wr_acc = wa; v.wr_ram = wm; v.rd_ram = rm; v.pc = p; v.halt = h; v.cnt = c;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      rst = 1'b0; en = 1'b0; instr = '0;
      w_rst = 1'b0; w_en = 1'b0; w_instr = '0;

      //        rst en instr     sa    sb op  wa wm rm  pc h  cnt
      vecs.push_back(mk(1, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 16'h1805, 2'b01, 0, 0, 1, 0, 0, 1, 0, 1)); // LDI 5
      vecs.push_back(mk(0, 1, 16'h2803, 2'b10, 1, 0, 1, 0, 0, 2, 0, 2)); // ADDI 3
      vecs.push_back(mk(0, 1, 16'h0802, 2'b00, 0, 0, 0, 1, 0, 3, 0, 3)); // STO 2
      vecs.push_back(mk(0, 1, 16'h0000, 2'b00, 0, 0, 0, 0, 0, 3, 1, 4)); // HLT
      vecs.push_back(mk(0, 1, 16'h1805, 2'b01, 0, 0, 0, 0, 0, 3, 1, 4)); // halted
      vecs.push_back(mk(0, 0, 16'h2803, 2'b10, 1, 0, 0, 0, 0, 3, 1, 4));
      vecs.push_back(mk(0, 1, 16'h3007, 2'b10, 0, 1, 0, 0, 0, 3, 1, 4));
      vecs.push_back(mk(1, 1, 16'h1805, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0)); // reset in HALT
      vecs.push_back(mk(1, 1, 16'h1805, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0)); // reset in RUN
      vecs.push_back(mk(0, 1, 16'h3007, 2'b10, 0, 1, 1, 0, 1, 1, 0, 1)); // SUB 7
      vecs.push_back(mk(0, 0, 16'h1805, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 16'h1805, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 1, 16'h1805, 2'b01, 0, 0, 1, 0, 0, 2, 0, 2)); // pulse
      vecs.push_back(mk(0, 0, 16'h2004, 2'b10, 0, 0, 0, 0, 0, 2, 0, 2));
      vecs.push_back(mk(0, 0, 16'h2004, 2'b10, 0, 0, 0, 0, 0, 2, 0, 2));
      vecs.push_back(mk(0, 1, 16'h2004, 2'b10, 0, 0, 1, 0, 1, 3, 0, 3)); // pulse ADD
      vecs.push_back(mk(0, 1, 16'hF8AB, 2'b00, 0, 0, 0, 0, 0, 4, 0, 4)); // opcode 11111
      vecs.push_back(mk(0, 1, 16'h4000, 2'b00, 0, 0, 0, 0, 0, 5, 0, 5)); // opcode 01000
      vecs.push_back(mk(0, 1, 16'h3801, 2'b10, 1, 1, 1, 0, 0, 6, 0, 6)); // SUBI 1
      vecs.push_back(mk(0, 1, 16'h1009, 2'b00, 0, 0, 1, 0, 1, 7, 0, 7)); // LD 9
      vecs.push_back(mk(0, 1, 16'h0000, 2'b00, 0, 0, 0, 0, 0, 7, 1, 8)); // HLT

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; en = vecs[i].en; instr = vecs[i].instr;
         #2;
         chk("sel_a",   i, 32'(sel_a),   32'(vecs[i].sel_a));
         chk("sel_b",   i, 32'(sel_b),   32'(vecs[i].sel_b));
         chk("op",      i, 32'(op),      32'(vecs[i].op));
         chk("wr_acc",  i, 32'(wr_acc),  32'(vecs[i].wr_acc));
         chk("wr_ram",  i, 32'(wr_ram),  32'(vecs[i].wr_ram));
         chk("rd_ram",  i, 32'(rd_ram),  32'(vecs[i].rd_ram));
         chk("operand", i, 32'(operand), 32'(vecs[i].instr[10:0]));
         @(posedge clk);
         #1;
         chk("pc",      i, 32'(pc),      32'(vecs[i].pc));
         chk("halt",    i, 32'(halt),    32'(vecs[i].halt));
         chk("count",   i, 32'(cnt),     32'(vecs[i].cnt));
         $display("step %0d rst=%0b en=%0b instr=%h -> pc=%0d halt=%0b count=%0d",
                  i, vecs[i].rst, vecs[i].en, vecs[i].instr, pc, halt, cnt);
      end

      // Narrow instance: PC wraps 7->0 and the 3-bit counter saturates at 7.
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      w_rst = 1'b1; w_en = 1'b1; w_instr = 16'h4000;
      @(posedge clk);
      #1;
      chk("wrap_rst_pc",  0, 32'(w_pc),  32'd0);
      chk("wrap_rst_cnt", 0, 32'(w_cnt), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         w_rst = 1'b0;
         #2;
         chk("wrap_wr_acc", k, 32'(w_wr_acc), 32'd0);
         @(posedge clk);
         #1;
         chk("wrap_pc",    k, 32'(w_pc),   32'((k + 1) % 8));
         chk("wrap_count", k, 32'(w_cnt),  32'((k + 1 > 7) ? 7 : k + 1));
         chk("wrap_halt",  k, 32'(w_halt), 32'd0);
         $display("wrap nop %0d -> pc=%0d count=%0d", k, w_pc, w_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of the accumulator processor; sits directly upstream of the operand-B selector and the accumulator-input selector.
- Holds the program counter and a RUN/HALT state machine, and decodes the current 16-bit instruction.
- Drives the B-select, A-select, ALU op and write strobes for the datapath, and passes the operand field to the sign extender and the data-memory address.
- Exposes halt status and an executed-instruction count for the debug unit.

Parameters:
- PC_BITS, 11, program counter width; program memory depth is 2^PC_BITS.
- OPC_BITS, 5, opcode field width (instruction bits [15:11]).
- OPR_BITS, 11, operand field width (instruction bits [10:0]).
- CNT_BITS, 16, executed-instruction counter width.

Ports:
- i_clock, in, 1, system clock; all state changes on the rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_enable, in, 1, execute enable from the debug unit; low freezes all state.
- i_instr, in, 16, instruction read asynchronously from program memory at o_pc.
- o_pc, out, PC_BITS, registered program counter.
- o_operand, out, OPR_BITS, i_instr[10:0]; goes to the sign extender and to the data-memory address.
- o_sel_a, out, 2, accumulator source: 00 data RAM, 01 sign-extended operand, 10 ALU.
- o_sel_b, out, 1, operand-B select: 0 data RAM, 1 sign-extended operand.
- o_op, out, 1, ALU op: 0 add, 1 subtract.
- o_wr_acc, out, 1, accumulator write strobe.
- o_wr_ram, out, 1, data-RAM write strobe.
- o_rd_ram, out, 1, data-RAM read strobe.
- o_halt, out, 1, high while in HALT.
- o_inst_count, out, CNT_BITS, number of instructions executed.

Behaviour:
- Reset (sampled on the clock edge while i_reset=1):
  - o_pc=0, state=RUN, o_inst_count=0.
  - All strobes are 0 in the reset cycle.
  - Reset overrides i_enable and HALT, and is valid at any time.
- Execute cycle: a cycle with state=RUN and i_enable=1.
- Decode is combinational from i_instr. Strobes are asserted only in an execute cycle; otherwise o_wr_acc, o_wr_ram and o_rd_ram are 0.
- o_sel_a, o_sel_b and o_op follow the decode at all times, with default 0 for HLT and unknown opcodes.
- Opcode decode:
  - 00000 HLT: no strobes. Next state HALT; PC does not advance.
  - 00001 STO: o_wr_ram=1.
  - 00010 LD: o_sel_a=00, o_rd_ram=1, o_wr_acc=1.
  - 00011 LDI: o_sel_a=01, o_wr_acc=1.
  - 00100 ADD: o_sel_a=10, o_sel_b=0, o_op=0, o_rd_ram=1, o_wr_acc=1.
  - 00101 ADDI: o_sel_a=10, o_sel_b=1, o_op=0, o_wr_acc=1.
  - 00110 SUB: as ADD but o_op=1.
  - 00111 SUBI: as ADDI but o_op=1.
  - Any other opcode: NOP, no strobes; PC advances.
- PC update:
  - In an execute cycle with a non-HLT opcode, o_pc <= o_pc+1 at the edge.
  - Wraps from 2^PC_BITS-1 to 0 with no flag.
- Counter:
  - o_inst_count increments once per execute cycle, HLT included.
  - Saturates at 2^CNT_BITS-1.
- HALT:
  - o_halt=1; PC and counter are frozen.
  - All strobes are 0 regardless of i_instr or i_enable.
  - The only exit is reset.
- i_enable=0 in RUN: no state change; strobes are 0. Used for single-stepping by pulsing i_enable for one cycle.
- Latency:
  - Control outputs are valid in the same cycle as i_instr.
  - The datapath commits at the edge that ends the execute cycle.
  - o_pc and o_halt update one edge after the execute cycle.

Test Plan:
- Reset, then hold i_enable=1 with program LDI 5; ADDI 3; STO 2; HLT:
  - PC sequence 0,1,2,3,3…
  - LDI cycle: o_sel_a=01, o_wr_acc=1.
  - ADDI cycle: o_sel_a=10, o_sel_b=1, o_op=0.
  - STO cycle: o_wr_ram=1, o_operand=2.
  - o_halt=1 after cycle 4; o_inst_count=4.
- SUB 7 with i_enable=1: o_sel_b=0, o_op=1, o_rd_ram=1, o_wr_acc=1, o_operand=7 in that cycle; PC advances by 1.
- Pulse i_enable for 1 cycle out of every 3 over 3 instructions:
  - PC advances only after pulse cycles; strobes are 0 in non-enabled cycles.
  - Final o_inst_count=3.
- Opcode 11111 executed: no strobes, PC+1, count+1.
- Wrap: set PC_BITS=3 and run 8 NOPs: o_pc wraps 7→0.
- Assert i_reset while in HALT with PC=3: next cycle PC=0, o_halt=0, count=0; execution resumes when i_enable=1.
